module_dequant_1x8: RTL and testbench
=====================================

Name: module_dequant_1x8

Overview:
- Eight-lane dequantizer; the inverse of the 1x8 requantizer that sits at the end of the convolution engine.
- Takes eight unsigned 8-bit activations with a shared zero point, scale and shift, and produces eight signed 18-bit accumulator-domain values.
- Used on route/concat and upsample paths, where tensors with different quantization parameters must be re-expressed in the MAC domain before requantization.
- 3-stage pipeline with valid/ready handshake on both sides; all lanes advance in lockstep.

Parameters:
- LANES, 8, number of parallel lanes; the bench and the top level use 8 only.
- ACC_W, 18, output width (signed).
- SHIFT_W, 4, width of the right-shift amount.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- quant_in  in  LANES*8  lane i at bits [8i+7:8i], unsigned
- scale  in  16  signed multiplier, sampled with the beat
- shift  in  SHIFT_W  arithmetic right shift 0..15, sampled with the beat
- zero_point  in  8  unsigned zero point, sampled with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- dequant_out  out  LANES*ACC_W  lane i at bits [ACC_W*i+ACC_W-1:ACC_W*i], signed

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
  - On reset: all stage valids = 0, out_valid = 0, dequant_out = 0, all pipeline data registers = 0.
  - Reset mid-operation discards every in-flight beat. No partial beat is emitted afterwards.
- Pipeline advance: global enable adv = !s3_valid || out_ready. in_ready = adv. All three stages shift when adv = 1.
- Stage 1 (on accept): d = {1'b0,q} - {1'b0,zero_point], 9-bit signed, range -255..255. scale and shift are registered alongside d.
- Stage 2: p = d * scale, 25-bit signed. |p| <= 255*32768 < 2^23, so no overflow.
- Stage 3: r = p >>> shift (arithmetic). Saturate r to [-131072, 131071] and register the result into dequant_out. s3_valid drives out_valid.
- Latency: 3 cycles from accept to out_valid when out_ready is held high. Throughput: 1 beat per cycle.
- Backpressure:
  - While out_valid && !out_ready, dequant_out and out_valid hold stable and the whole pipe freezes.
  - Bubbles are not compressed.
  - No beat is dropped or duplicated, and beat order is preserved.
- Simultaneous events: out_ready and in_valid high in the same cycle with s3 full means s3 retires and a new beat enters s1 in that same edge.
- Parameter changes between beats take effect per beat, with no flush needed, because parameters travel with the data.
- shift = 0: no shift. Saturation is still applied.
- in_valid low: bubbles propagate as valid = 0. Data registers may hold stale values, but out_valid = 0.

Optional Feature:
- Macro: DEQUANT_ROUND_EN.
- Defined: stage 3 computes r = (p + (shift != 0 ? 1 << (shift-1) : 0)) >>> shift, i.e. round-half-up toward +inf. The adder is 25-bit, so there is no overflow.
- Undefined: plain arithmetic shift, i.e. floor. Latency and handshake are identical in both builds.

Decomposition:
- Shared package `quant_pkg`:
  - constants ACT_W = 8, ACC_W = 18, SCALE_W = 16, SHIFT_W = 4, PROD_W = 25
  - ACC_MAX = 131071, ACC_MIN = -131072
  - a saturate function from PROD_W to ACC_W
  - The requantizer shares this package.
- One sub-module, `module_dequant_lane`:
  - holds the stage-1/2/3 data registers for one lane, gated by the shared adv.
  - The top generates LANES instances and owns the valid chain and the handshake.

Test Plan:
- Basic: q=200, zp=128, scale=1024, shift=4, out_ready=1 -> lane = 4608 exactly 3 cycles after accept; all 8 lanes driven with distinct q values and checked independently.
- Rounding:
  - q=129, zp=128, scale=3, shift=1 -> 1 without DEQUANT_ROUND_EN, 2 with it.
  - q=127, same parameters -> -2 without, -1 with.
- Saturation:
  - q=255, zp=0, scale=32767, shift=0 -> 131071.
  - q=0, zp=255, scale=32767, shift=0 -> -131072.
  - q=255, zp=0, scale=-32768, shift=15 -> -255.
- Backpressure: stream 6 beats with out_ready=0 from cycle 0 -> exactly 3 accepted, then in_ready=0. dequant_out stays stable while stalled. Release out_ready -> all 6 emerge in order, no loss, no duplicate.
- Throughput and per-beat parameters: 16 back-to-back beats with scale/zp/shift changed every beat and out_ready=1 -> one output per cycle, each matching its own parameters. Random out_ready toggling is checked against a reference model.
- Reset mid-operation: assert rst with 3 beats in flight -> out_valid=0 and dequant_out=0 immediately (asynchronous). After release, the next accepted beat is the first one out, after 3 cycles.

Source files
------------

// File: rtl/quant_pkg.sv
// Constants and the saturation helper shared by the 1x8 dequantizer and requantizer.
package quant_pkg;

  localparam int ACT_W   = 8;
  localparam int ACC_W   = 18;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 4;
  localparam int PROD_W  = 25;

  localparam int ACC_MAX = 131071;
  localparam int ACC_MIN = -131072;

  // Clamp a full-width product-domain value into the signed accumulator range.
  function automatic logic signed [ACC_W-1:0] satAcc(input logic signed [PROD_W-1:0] v);
    if (int'(v) > ACC_MAX) return ACC_W'(ACC_MAX);
    if (int'(v) < ACC_MIN) return ACC_W'(ACC_MIN);
    return ACC_W'(v);
  endfunction

endpackage

// File: rtl/module_dequant_lane.sv
// One dequantizer lane: subtract zero point, multiply by scale, shift and saturate.
// Rounding before the shift is enabled by defining DEQUANT_ROUND_EN.
module module_dequant_lane
  import quant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_adv,
  input  logic [ACT_W-1:0]          i_quant,
  input  logic [ACT_W-1:0]          i_zero_point,
  input  logic signed [SCALE_W-1:0] i_scale,
  input  logic [SHIFT_W-1:0]        i_shift,
  output logic signed [ACC_W-1:0]   o_dequant
);

  logic signed [ACT_W:0]    r_d;
  logic signed [SCALE_W-1:0] r_scale1;
  logic [SHIFT_W-1:0]       r_shift1;
  logic signed [PROD_W-1:0] r_p;
  logic [SHIFT_W-1:0]       r_shift2;
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [ACT_W:0]    w_diff;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_bias;
  logic signed [PROD_W-1:0] w_sum;
  logic signed [PROD_W-1:0] w_shifted;

  assign w_diff = $signed({1'b0, i_quant} - {1'b0, i_zero_point});
  assign w_prod = PROD_W'(r_d) * PROD_W'(r_scale1);

`ifdef DEQUANT_ROUND_EN
  // Half-LSB bias makes the following arithmetic shift round half toward +inf.
  always_comb begin
    w_bias = '0;
    if (r_shift2 != '0) w_bias = PROD_W'(1) <<< (r_shift2 - 1'b1);
  end
`else
  assign w_bias = '0;
`endif

  assign w_sum     = r_p + w_bias;
  assign w_shifted = w_sum >>> r_shift2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d      <= '0;
      r_scale1 <= '0;
      r_shift1 <= '0;
      r_p      <= '0;
      r_shift2 <= '0;
      r_acc    <= '0;
    end else if (i_adv) begin
      r_d      <= w_diff;
      r_scale1 <= i_scale;
      r_shift1 <= i_shift;
      r_p      <= w_prod;
      r_shift2 <= r_shift1;
      r_acc    <= satAcc(w_shifted);
    end
  end

  assign o_dequant = r_acc;

endmodule

// File: rtl/module_dequant_1x8.sv
// Eight-lane 3-stage dequantizer with valid/ready on both sides; lanes move in lockstep.
// Optional round-half-up before the shift when DEQUANT_ROUND_EN is defined.
module module_dequant_1x8
  import quant_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int ACC_W   = 18,
  parameter int SHIFT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*8-1:0]       quant_in,
  input  logic [15:0]              scale,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic [7:0]               zero_point,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*ACC_W-1:0]   dequant_out
);

  logic r_v1;
  logic r_v2;
  logic r_v3;
  logic w_adv;

  // The whole pipe moves together; it only stalls when the last stage is full and blocked.
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    module_dequant_lane u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_adv        (w_adv),
      .i_quant      (quant_in[8*g +: 8]),
      .i_zero_point (zero_point),
      .i_scale      (scale),
      .i_shift      (shift),
      .o_dequant    (dequant_out[ACC_W*g +: ACC_W])
    );
  end

endmodule

// File: tb/tb_module_dequant_1x8.sv
// Self-checking bench for module_dequant_1x8: arithmetic reference model plus scoreboard,
// with directed literal checks on latency, rounding, saturation, backpressure and reset.
module tb_module_dequant_1x8;

  typedef logic [8*18-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] quant_in = '0;
  logic [15:0] scale = '0;
  logic [3:0]  shift = '0;
  logic [7:0]  zero_point = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  vec_t        dequant_out;

  int   assertions = 0;
  int   failures = 0;
  int   outCount = 0;
  vec_t expQ[$];

  always #5 clk = ~clk;

  module_dequant_1x8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .quant_in    (quant_in),
    .scale       (scale),
    .shift       (shift),
    .zero_point  (zero_point),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dequant_out (dequant_out)
  );

`ifdef DEQUANT_ROUND_EN
  localparam int EXP_RND_POS = 2;
  localparam int EXP_RND_NEG = -1;
`else
  localparam int EXP_RND_POS = 1;
  localparam int EXP_RND_NEG = -2;
`endif

  // Reference: plain integer arithmetic on one lane.
  function automatic int deqModel(int q, int zp, int sc, int sh);
    int p;
    p = (q - zp) * sc;
`ifdef DEQUANT_ROUND_EN
    if (sh != 0) p = p + (1 << (sh - 1));
`endif
    p = p >>> sh;
    if (p > 131071) p = 131071;
    if (p < -131072) p = -131072;
    return p;
  endfunction

  function automatic vec_t buildExp();
    vec_t v;
    for (int i = 0; i < 8; i++)
      v[18*i +: 18] = 18'(deqModel(int'(quant_in[8*i +: 8]), int'(zero_point),
                                   int'($signed(scale)), int'(shift)));
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkVec(input string name, input vec_t actual, input vec_t expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] q, input int zp, input int sc,
                               input int sh, input logic v);
    quant_in   = q;
    zero_point = 8'(zp);
    scale      = 16'(sc);
    shift      = 4'(sh);
    in_valid   = v;
  endtask

  function automatic logic [63:0] beatQ(int k);
    logic [63:0] q;
    for (int i = 0; i < 8; i++) q[8*i +: 8] = 8'((k * 37 + i * 29 + 11) & 255);
    return q;
  endfunction

  task automatic applyBeat(input int k, input logic v);
    applyStimulus(beatQ(k), (k * 13) & 255, ((k * 2741) % 65536) - 32768, k % 16, v);
  endtask

  // Scoreboard: every output beat is compared with the model, stalled cycles included.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
    end else begin
      checkOutput("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (out_valid) begin
        if (expQ.size() == 0) checkOutput("unexpected_beat", 1, 0);
        else begin
          checkVec("beat_data", dequant_out, expQ[0]);
          if (out_ready) begin
            void'(expQ.pop_front());
            outCount++;
          end
        end
      end
      if (in_valid && in_ready) expQ.push_back(buildExp());
    end
  end

  task automatic runBeat(input string name, input logic [63:0] q, input int zp, input int sc,
                         input int sh, input int exp0);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(q, zp, sc, sh, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        n = k;
      end
    end
    checkOutput({name, "_latency"}, n, 3);
    if (got) checkOutput({name, "_lane0"}, $signed(dequant_out[17:0]), exp0);
  endtask

  // readyMode: 0 hold low, 1 hold high, 2 random; randValid inserts random bubbles.
  task automatic feedBeats(input int first, input int n, input int maxCycles, input int readyMode,
                           input bit randValid, output int accepted, output int cycles);
    int k;
    bit acc;
    k = first;
    cycles = 0;
    @(posedge clk); #1;
    applyBeat(k, randValid ? 1'($urandom_range(0, 1)) : 1'b1);
    out_ready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'(readyMode);
    while (k < first + n && cycles < maxCycles) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) k++;
      if (k < first + n) applyBeat(k, randValid ? 1'($urandom_range(0, 1)) : 1'b1);
      else in_valid = 1'b0;
      if (readyMode == 2) out_ready = 1'($urandom_range(0, 1));
    end
    accepted = k - first;
  endtask

  task automatic waitDrain(input string name);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 50 && (expQ.size() != 0 || out_valid); k++) @(negedge clk);
    #1;
    checkOutput({name, "_drained"}, expQ.size(), 0);
  endtask

  initial begin
    int acc;
    int cyc;
    int startCount;
    vec_t held;

    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkVec("reset_dequant_out", dequant_out, '0);
    #10 rst = 1'b0;

    checkOutput("model_basic", deqModel(200, 128, 1024, 4), 4608);
    checkOutput("model_round_pos", deqModel(129, 128, 3, 1), EXP_RND_POS);
    checkOutput("model_round_neg", deqModel(127, 128, 3, 1), EXP_RND_NEG);
    checkOutput("model_sat_neg", deqModel(0, 255, 32767, 0), -131072);

    runBeat("basic", {8'd127, 8'd129, 8'd60, 8'd10, 8'd128, 8'd255, 8'd0, 8'd200},
            128, 1024, 4, 4608);
    checkOutput("basic_lane1", $signed(dequant_out[35:18]), -8192);
    checkOutput("basic_lane2", $signed(dequant_out[53:36]), 8128);
    checkOutput("basic_lane3", $signed(dequant_out[71:54]), 0);

    runBeat("round_pos", {{7{8'd50}}, 8'd129}, 128, 3, 1, EXP_RND_POS);
    runBeat("round_neg", {{7{8'd50}}, 8'd127}, 128, 3, 1, EXP_RND_NEG);
    runBeat("sat_max", {{7{8'd1}}, 8'd255}, 0, 32767, 0, 131071);
    runBeat("sat_min", {{7{8'd1}}, 8'd0}, 255, 32767, 0, -131072);
    runBeat("big_shift", {{7{8'd1}}, 8'd255}, 0, -32768, 15, -255);
    waitDrain("directed");

    // Backpressure: sink blocked from the start, only three beats fit.
    startCount = outCount;
    feedBeats(0, 6, 10, 0, 1'b0, acc, cyc);
    checkOutput("bp_accepted", acc, 3);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    held = dequant_out;
    repeat (3) @(negedge clk);
    checkVec("bp_stable", dequant_out, held);
    feedBeats(3, 3, 20, 1, 1'b0, acc, cyc);
    checkOutput("bp_rest_accepted", acc, 3);
    waitDrain("bp");
    checkOutput("bp_out_count", outCount - startCount, 6);

    // Full-rate streaming with parameters changing every beat.
    startCount = outCount;
    feedBeats(100, 16, 40, 1, 1'b0, acc, cyc);
    checkOutput("tput_accepted", acc, 16);
    checkOutput("tput_cycles", cyc, 16);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("tput_out_count", outCount - startCount, 16);
    waitDrain("tput");

    // Random bubbles and random backpressure against the scoreboard.
    startCount = outCount;
    feedBeats(200, 40, 600, 2, 1'b1, acc, cyc);
    checkOutput("rand_accepted", acc, 40);
    waitDrain("rand");
    checkOutput("rand_out_count", outCount - startCount, 40);

    // Reset with three beats in flight.
    feedBeats(300, 3, 10, 1, 1'b0, acc, cyc);
    checkOutput("rst_prefill", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", out_valid, 0);
    checkVec("rst_async_data", dequant_out, '0);
    @(negedge clk);
    #1 rst = 1'b0;
    runBeat("after_rst", {8'd127, 8'd129, 8'd60, 8'd10, 8'd128, 8'd255, 8'd0, 8'd200},
            128, 1024, 4, 4608);
    waitDrain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
